instr_fetch_decode: RTL

Multicycle instruction-fetch and field-decode unit for the CPU datapath. On a fetch request from the control unit it reads one word from instruction memory at the supplied PC, waits a fixed memory latency, latches the word into the instruction register, and presents it split into its MIPS fields. It is the inverse of jump-target assembly: it unpacks the `rs`/`rt`/`imm16` fields and the 26-bit jump index that later get reassembled, and it also provides `pc_plus4`.

---
 rtl/instr_fetch_decode.sv | 130 +++++++++++++
 1 files changed

// File: rtl/instr_fetch_decode.sv
// Multicycle instruction fetch with MIPS field decode.
// A fetch request reads one word from instruction memory. The word is captured
// into the instruction register after a fixed memory latency, and that
// register is presented as MIPS fields. pc_in + 4 is latched alongside the fetch.
module instr_fetch_decode #(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic [31:0] pc_in,
    input  logic [31:0] mem_rdata,
    input  logic        ir_ack,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    output logic        busy,
    output logic        instr_valid,
    output logic        addr_err,
    output logic [31:0] ir,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm16,
    output logic [25:0] jidx,
    output logic [31:0] pc_plus4
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        FULL = 2'd2
    } state_t;

    // Loaded on request so that reaching zero lines up with the data-sampling edge.
    localparam logic [2:0] LAT_INIT = 3'(MEM_LAT - 1);

    state_t     state, state_nx;
    logic [2:0] lat_cnt, lat_cnt_nx;
    logic       take_req;   // a request is being considered this cycle
    logic       accept;     // aligned request starts a memory read
    logic       reject;     // misaligned request is refused
    logic       load_ir;    // memory data is captured this edge

    // Next-state decode; a request seen in IDLE or alongside ir_ack in FULL is
    // handled identically, which gives back-to-back fetches without an idle gap.
    always_comb begin
        state_nx   = state;
        lat_cnt_nx = lat_cnt;
        take_req   = 1'b0;
        accept     = 1'b0;
        reject     = 1'b0;
        load_ir    = 1'b0;
        case (state)
            IDLE: take_req = fetch_req;
            WAIT: begin
                if (lat_cnt == 3'd0) begin
                    load_ir  = 1'b1;
                    state_nx = FULL;
                end else begin
                    lat_cnt_nx = lat_cnt - 3'd1;
                end
            end
            FULL: begin
                if (ir_ack) begin
                    state_nx = IDLE;
                    take_req = fetch_req;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (take_req) begin
            if (pc_in[1:0] == 2'b00) begin
                accept     = 1'b1;
                state_nx   = WAIT;
                lat_cnt_nx = LAT_INIT;
            end else begin
                reject   = 1'b1;
                state_nx = IDLE;
            end
        end
    end

    // State and latency counter; reset abandons any read in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            lat_cnt <= 3'd0;
        end else begin
            state   <= state_nx;
            lat_cnt <= lat_cnt_nx;
        end
    end

    // Address, strobes, PC+4 and instruction register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr <= 32'd0;
            pc_plus4 <= 32'd0;
            mem_rd   <= 1'b0;
            addr_err <= 1'b0;
            ir       <= 32'd0;
        end else begin
            mem_rd   <= accept;
            addr_err <= reject;
            if (accept) begin
                mem_addr <= pc_in;
                pc_plus4 <= pc_in + 32'd4;
            end
            if (load_ir) begin
                ir <= mem_rdata;
            end
        end
    end

    assign busy        = (state == WAIT);
    assign instr_valid = (state == FULL);

    assign opcode = ir[31:26];
    assign rs     = ir[25:21];
    assign rt     = ir[20:16];
    assign rd     = ir[15:11];
    assign shamt  = ir[10:6];
    assign funct  = ir[5:0];
    assign imm16  = ir[15:0];
    assign jidx   = ir[25:0];

endmodule
